// File: rtl/set_time.sv
`default_nettype none
// ============================================================================
// Module      : set_time
// Description : Time-entry block. Captures clamped switch values into
//               hours/minutes/seconds one field per "next" button press.
// Revision    : 1.0 - initial release
// ============================================================================
module set_time #(
    parameter logic [2:0] SET_STATE = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       nxt_but,
    input  logic [5:0] in_time,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] field
);

    localparam logic [1:0] c_FLD_HOURS   = 2'd0;
    localparam logic [1:0] c_FLD_MINUTES = 2'd1;
    localparam logic [1:0] c_FLD_SECONDS = 2'd2;

    localparam logic [5:0] c_MAX_HOURS = 6'd23;
    localparam logic [5:0] c_MAX_MINSEC = 6'd59;

    logic [4:0] r_hours;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic [1:0] r_field;
    logic       r_nxt_prev;
    logic       r_armed;

    logic       w_in_set;
    logic       w_press;
    logic       w_accept;
    logic [4:0] w_clamp_hours;
    logic [5:0] w_clamp_minsec;
    logic [1:0] w_field_next;

    // A button already held at reset release must be seen low once before it
    // can count as a press; r_armed records that.
    assign w_in_set = (state == SET_STATE);
    assign w_press  = nxt_but & ~r_nxt_prev & r_armed;
    assign w_accept = w_press & w_in_set;

    assign w_clamp_hours  = (in_time > c_MAX_HOURS) ? c_MAX_HOURS[4:0] : in_time[4:0];
    assign w_clamp_minsec = (in_time > c_MAX_MINSEC) ? c_MAX_MINSEC : in_time;

    always_comb begin
        w_field_next = r_field;
        if (!w_in_set) begin
            w_field_next = c_FLD_HOURS;
        end else if (w_accept) begin
            case (r_field)
                c_FLD_HOURS:   w_field_next = c_FLD_MINUTES;
                c_FLD_MINUTES: w_field_next = c_FLD_SECONDS;
                default:       w_field_next = c_FLD_HOURS;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nxt_prev <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_nxt_prev <= nxt_but;
            r_armed    <= r_armed | ~nxt_but;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hours   <= 5'd0;
            r_minutes <= 6'd0;
            r_seconds <= 6'd0;
            r_field   <= c_FLD_HOURS;
        end else begin
            r_field <= w_field_next;
            if (w_accept) begin
                case (r_field)
                    c_FLD_HOURS:   r_hours   <= w_clamp_hours;
                    c_FLD_MINUTES: r_minutes <= w_clamp_minsec;
                    default:       r_seconds <= w_clamp_minsec;
                endcase
            end
        end
    end

    assign hours   = r_hours;
    assign minutes = r_minutes;
    assign seconds = r_seconds;
    assign field   = r_field;

endmodule
`default_nettype wire

// File: tb/tb_set_time.sv
`default_nettype none
// Directed bench for set_time: expected outputs are queued as each step is
// driven and compared against the DUT after the clock edge.
module tb_set_time;

    localparam logic [2:0] c_SET  = 3'b010;
    localparam logic [2:0] c_IDLE = 3'b000;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [1:0] f;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] state;
    logic       nxt_but;
    logic [5:0] in_time;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] field;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    set_time #(.SET_STATE(3'b010)) dut (
        .clk     (clk),
        .reset   (reset),
        .state   (state),
        .nxt_but (nxt_but),
        .in_time (in_time),
        .hours   (hours),
        .minutes (minutes),
        .seconds (seconds),
        .field   (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input logic [4:0] h, input logic [5:0] m,
                              input logic [5:0] s, input logic [1:0] f);
        exp_t e;
        e.h = h; e.m = m; e.s = s; e.f = f;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s scoreboard empty got=0 want=1", tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            assert (hours === e.h) else begin
                bad++; $error("FAIL %s hours got=%0d want=%0d", tag, hours, e.h);
            end
            total++;
            assert (minutes === e.m) else begin
                bad++; $error("FAIL %s minutes got=%0d want=%0d", tag, minutes, e.m);
            end
            total++;
            assert (seconds === e.s) else begin
                bad++; $error("FAIL %s seconds got=%0d want=%0d", tag, seconds, e.s);
            end
            total++;
            assert (field === e.f) else begin
                bad++; $error("FAIL %s field got=%0d want=%0d", tag, field, e.f);
            end
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, settle 1 time unit.
    task automatic step(input logic [2:0] st, input logic nb, input logic [5:0] t);
        @(negedge clk);
        state = st; nxt_but = nb; in_time = t;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [5:0] t, input string tag,
                         input logic [4:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic [1:0] f);
        step(c_SET, 1'b1, t);
        expect_out(h, m, s, f);
        check(tag);
        step(c_SET, 1'b0, t);
    endtask

    initial begin
        reset = 1'b1; state = c_SET; nxt_but = 1'b0; in_time = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_out(5'd0, 6'd0, 6'd0, 2'd0);
        check("reset_state");
        @(negedge clk);
        reset = 1'b0;
        step(c_SET, 1'b0, 6'd0);

        // Basic three-field entry
        press(6'd7, "enter_h7", 5'd7, 6'd0, 6'd0, 2'd1);
        press(6'd8, "enter_m8", 5'd7, 6'd8, 6'd0, 2'd2);
        press(6'd9, "enter_s9", 5'd7, 6'd8, 6'd9, 2'd0);

        // Saturating clamp
        press(6'd63, "clamp_h63", 5'd23, 6'd8,  6'd9,  2'd1);
        press(6'd63, "clamp_m63", 5'd23, 6'd59, 6'd9,  2'd2);
        press(6'd63, "clamp_s63", 5'd23, 6'd59, 6'd59, 2'd0);

        // Held button counts once
        step(c_SET, 1'b1, 6'd5);
        expect_out(5'd5, 6'd59, 6'd59, 2'd1);
        check("hold_first");
        repeat (9) step(c_SET, 1'b1, 6'd5);
        expect_out(5'd5, 6'd59, 6'd59, 2'd1);
        check("hold_10cyc");
        step(c_SET, 1'b0, 6'd5);

        // Presses outside SET_STATE ignored; field forced to hours
        step(c_IDLE, 1'b1, 6'd12);
        expect_out(5'd5, 6'd59, 6'd59, 2'd0);
        check("idle_ignore");
        step(c_IDLE, 1'b0, 6'd12);
        step(c_SET, 1'b0, 6'd12);
        press(6'd12, "return_h12", 5'd12, 6'd59, 6'd59, 2'd1);

        // Press coinciding with leaving / entering SET_STATE
        step(c_IDLE, 1'b1, 6'd3);
        expect_out(5'd12, 6'd59, 6'd59, 2'd0);
        check("leave_press");
        step(c_IDLE, 1'b0, 6'd3);
        step(c_SET, 1'b1, 6'd3);
        expect_out(5'd3, 6'd59, 6'd59, 2'd1);
        check("enter_press");
        step(c_SET, 1'b0, 6'd3);

        // in_time wiggle without press
        step(c_SET, 1'b0, 6'd0);
        step(c_SET, 1'b0, 6'd63);
        expect_out(5'd3, 6'd59, 6'd59, 2'd1);
        check("wiggle_63");
        step(c_SET, 1'b0, 6'd17);
        expect_out(5'd3, 6'd59, 6'd59, 2'd1);
        check("wiggle_17");

        // Reset mid-entry, asynchronous
        step(c_IDLE, 1'b0, 6'd0);
        step(c_SET, 1'b0, 6'd0);
        press(6'd4,  "pre_rst_h4",  5'd4, 6'd59, 6'd59, 2'd1);
        press(6'd30, "pre_rst_m30", 5'd4, 6'd30, 6'd59, 2'd2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        expect_out(5'd0, 6'd0, 6'd0, 2'd0);
        check("async_reset");
        reset = 1'b0;

        // Button held across reset release
        @(negedge clk);
        nxt_but = 1'b1; in_time = 6'd9; state = c_SET;
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        step(c_SET, 1'b1, 6'd9);
        step(c_SET, 1'b1, 6'd9);
        expect_out(5'd0, 6'd0, 6'd0, 2'd0);
        check("held_at_release");
        step(c_SET, 1'b0, 6'd9);
        press(6'd9, "after_release", 5'd9, 6'd0, 6'd0, 2'd1);

        // Clamp boundaries
        press(6'd60, "bound_m60", 5'd9,  6'd59, 6'd0,  2'd2);
        press(6'd58, "bound_s58", 5'd9,  6'd59, 6'd58, 2'd0);
        press(6'd24, "bound_h24", 5'd23, 6'd59, 6'd58, 2'd1);
        press(6'd59, "bound_m59", 5'd23, 6'd59, 6'd58, 2'd2);
        press(6'd0,  "bound_s0",  5'd23, 6'd59, 6'd0,  2'd0);
        press(6'd22, "bound_h22", 5'd22, 6'd59, 6'd0,  2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/set_time.md
SET_TIME -- requirements
Module: set_time

Interface
REQ-001 SHALL have parameter SET_STATE, default 3'b010: the state code in which time entry is enabled.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port state, input, 3 bits: the clock system's current mode; entry is enabled only when it equals SET_STATE.
REQ-006 SHALL have port nxt_but, input, 1 bit: the "next" button; it is level-sensitive, already debounced and synchronous to clk.
REQ-007 SHALL have port in_time, input, 6 bits: the switch value (unsigned) for the currently selected field.
REQ-008 SHALL have port hours, output, 5 bits: the stored hours, 0-23.
REQ-009 SHALL have port minutes, output, 6 bits: the stored minutes, 0-59.
REQ-010 SHALL have port seconds, output, 6 bits: the stored seconds, 0-59.
REQ-011 SHALL have port field, output, 2 bits: the currently selected field; 2'd0 = hours, 2'd1 = minutes, 2'd2 = seconds; 2'd3 never occurs.

Function
REQ-012 SHALL register nxt_but every cycle into nxt_prev; a press is a cycle with nxt_but=1 and nxt_prev=0 (rising edge); holding the button SHALL yield exactly one press.
REQ-013 SHALL, on a press with state==SET_STATE, capture in_time into the field selected by field, visible on the outputs after that same clock edge (1-cycle latency).
REQ-014 SHALL advance field on each accepted press: hours -> minutes -> seconds -> hours (wrap-around).
REQ-015 SHALL clamp captured values as follows: hours = min(in_time, 23), truncated to 5 bits after clamping; minutes and seconds = min(in_time, 59).
REQ-016 SHALL leave the unselected fields unchanged on a capture.
REQ-017 SHALL, when state!=SET_STATE, ignore presses, hold hours/minutes/seconds, and force field to hours on the next edge.
REQ-018 SHALL, if state changes to SET_STATE in the same cycle as a press, accept that press; if state leaves SET_STATE in the same cycle, ignore it.
REQ-019 SHALL keep in_time changes without a press from affecting any output.
REQ-020 SHALL never produce hours>23, minutes>59 or seconds>59 under any input sequence.

Reset
REQ-021 SHALL, while reset=1, immediately set hours=0, minutes=0, seconds=0, field=hours and nxt_prev=0, regardless of clk.
REQ-022 SHALL, when reset is asserted mid-entry, abort the entry: the partially entered fields are lost and entry restarts at hours after release.
REQ-023 SHALL, when nxt_but is already high as reset releases, treat it as a press only if it is seen low for at least one cycle first; nxt_prev SHALL take the value 1 on the first clock after release.

Verification
REQ-024 SHALL be covered by this directed scenario: state=3'b010; in_time=7, press; in_time=8, press; in_time=9, press -> hours=7, minutes=8, seconds=9, field=0.
REQ-025 SHALL be covered by this directed scenario: in_time=6'd63 entered into all three fields -> hours=23, minutes=59, seconds=59.
REQ-026 SHALL be covered by this directed scenario: nxt_but held high for 10 cycles with in_time=5 -> only hours=5, field=1; minutes/seconds unchanged.
REQ-027 SHALL be covered by this directed scenario: state=3'b000, in_time=12, press -> outputs unchanged and field=0; after return to 3'b010, the next press writes hours.
REQ-028 SHALL be covered by this directed scenario: after hours=4 and minutes=30 are entered, reset pulsed between clock edges -> all outputs 0 immediately, field=0.
REQ-029 SHALL be covered by this directed scenario: in_time toggled 0->63->17 with no press -> outputs constant.
